// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one bit per clock,
// with start/done handshake, borrow-out and signed-overflow flag.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb;
  logic             r_bmsb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_next;

  full_subtractor u_cell (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  assign w_accept  = start && (r_state != RUN);
  assign w_last    = (r_state == RUN) && (r_cnt == LAST);
  assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sa   <= a;
        r_sb   <= b;
        r_br   <= bin;
        r_cnt  <= '0;
        r_amsb <= a[WIDTH-1];
        r_bmsb <= b[WIDTH-1];
      end else if (r_state == RUN) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_sr  <= w_sr_next;
        r_br  <= w_bo;
        r_cnt <= r_cnt + CW'(1);
      end
      // Results are published only on the final bit so they hold through the next run.
      if (w_last) begin
        r_diff   <= w_sr_next;
        r_borrow <= w_bo;
        r_ovf    <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;

endmodule
